// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg
//   Shared PS/2 definitions for the host transmitter and the paired keyboard receiver.
//   - FSM state encodings for the send side
//   - PS2_FRAME_FALLS: device clock falls per host-to-device frame, ACK included
//   - Common command bytes
//   - odd_parity(): the parity bit that makes the 9-bit data+parity field odd
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  localparam int         PS2_FRAME_FALLS  = 11;
  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync
//   Three-flop synchronizer plus falling-edge detect for one PS/2 pin.
//   Ports:
//     clk   in   system clock
//     clrn  in   synchronous active-low reset (flops reset to the idle-high line level)
//     pin   in   asynchronous pin level
//     level out  synchronized level
//     fall  out  1 for one cycle when the synchronized level goes 1 -> 0
//   A pin change is visible on level/fall two edges later and acted on by
//   the consuming FSM at the third.
module ps2_line_sync (
  input  logic clk,
  input  logic clrn,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [2:0] s;

  always_ff @(posedge clk) begin
    if (!clrn) s <= 3'b111;
    else       s <= {s[1:0], pin};
  end

  assign level = s[1];
  assign fall  = s[2] & ~s[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
//   Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send,
//   shifts one command byte + odd parity + stop on device clock falls, then
//   checks the device ACK.
//   Ports:
//     clk, clrn          system clock, synchronous active-low reset
//     tx_data/tx_valid   command byte, accepted when tx_ready
//     tx_ready           1 only in IDLE
//     ps2_clk/ps2_data   raw pin levels (asynchronous)
//     ps2_*_pull_low     1 = pad drives the line low (open drain)
//     busy               1 outside IDLE
//     done/ack_err       1-cycle outcome pulses
//     timeout_err        1-cycle watchdog pulse
//   Build option: define PS2_HOST_TX_TIMEOUT_EN to enable a watchdog that
//   abandons the frame TIMEOUT_CYCLES after RTS entry; without it timeout_err
//   is constant 0 and the FSM waits for the device indefinitely.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_pull_low,
  output logic       ps2_data_pull_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout_err
);
  import ps2_host_tx_pkg::*;

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  // index 0 = clock pin, 1 = data pin
  logic [1:0] pin_raw, pin_lvl, pin_fall;
  assign pin_raw = {ps2_data, ps2_clk};

  for (genvar i = 0; i < 2; i++) begin : g_sync
    ps2_line_sync u_sync (
      .clk   (clk),
      .clrn  (clrn),
      .pin   (pin_raw[i]),
      .level (pin_lvl[i]),
      .fall  (pin_fall[i])
    );
  end

  logic clk_fall, clk_lvl, data_lvl;
  assign clk_fall = pin_fall[0];
  assign clk_lvl  = pin_lvl[0];
  assign data_lvl = pin_lvl[1];

  // The send side never needs the data-line edge.
  logic unused_data_fall;
  assign unused_data_fall = pin_fall[1];

  ps2_tx_state_t state;
  logic [7:0]    tx_byte;
  logic          par;
  logic [3:0]    bitcnt;
  logic [IW-1:0] inh_cnt;

`ifdef PS2_HOST_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wd_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state             <= IDLE;
      tx_ready          <= 1'b1;
      busy              <= 1'b0;
      ps2_clk_pull_low  <= 1'b0;
      ps2_data_pull_low <= 1'b0;
      done              <= 1'b0;
      ack_err           <= 1'b0;
      timeout_err       <= 1'b0;
      tx_byte           <= '0;
      par               <= 1'b0;
      bitcnt            <= '0;
      inh_cnt           <= '0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
      wd_cnt            <= '0;
`endif
    end else begin
      done        <= 1'b0;
      ack_err     <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (tx_valid) begin
            tx_byte          <= tx_data;
            par              <= odd_parity(tx_data);
            bitcnt           <= '0;
            inh_cnt          <= '0;
            ps2_clk_pull_low <= 1'b1;
            tx_ready         <= 1'b0;
            busy             <= 1'b1;
            state            <= INHIBIT;
          end
        end

        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          // start bit goes low during the last inhibit cycle so data is
          // already held when the clock is released
          if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) ps2_data_pull_low <= 1'b1;
          if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_pull_low  <= 1'b0;
            ps2_data_pull_low <= 1'b1;
            state             <= RTS;
          end
        end

        RTS: state <= SHIFT;

        SHIFT: begin
          if (clk_fall) begin
            if (bitcnt != 4'(PS2_FRAME_FALLS)) bitcnt <= bitcnt + 1'b1;
            if (bitcnt < 4'd8)       ps2_data_pull_low <= ~tx_byte[bitcnt[2:0]];
            else if (bitcnt == 4'd8) ps2_data_pull_low <= ~par;
            else begin
              ps2_data_pull_low <= 1'b0;  // stop bit: release the line
              state             <= ACK;
            end
          end
        end

        ACK: begin
          if (clk_fall) begin
            if (bitcnt != 4'(PS2_FRAME_FALLS)) bitcnt <= bitcnt + 1'b1;
            if (!data_lvl) state <= WAIT_IDLE;
            else begin
              ack_err  <= 1'b1;
              busy     <= 1'b0;
              tx_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        WAIT_IDLE: begin
          if (clk_lvl && data_lvl) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            tx_ready <= 1'b1;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

`ifdef PS2_HOST_TX_TIMEOUT_EN
      // Watchdog runs from RTS entry; on expiry it overrides whatever the
      // FSM decided this cycle, including a simultaneous done.
      if (state == RTS || state == SHIFT || state == ACK || state == WAIT_IDLE) begin
        if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
          timeout_err       <= 1'b1;
          done              <= 1'b0;
          ack_err           <= 1'b0;
          ps2_clk_pull_low  <= 1'b0;
          ps2_data_pull_low <= 1'b0;
          busy              <= 1'b0;
          tx_ready          <= 1'b1;
          state             <= IDLE;
          wd_cnt            <= '0;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end else begin
        wd_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
//   Scoreboard bench for ps2_host_tx with a behavioural PS/2 device model.
//   Device clock period is scaled to 2*HALF system clocks to keep runs short.
module tb_ps2_host_tx;
  localparam int INH  = 50;
  localparam int TO   = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk, ps2_data, clk_pl, data_pl, busy, done, ack_err, timeout_err;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;

  // open-drain bus with pull-ups
  assign ps2_clk  = ~(clk_pl | dev_clk_low);
  assign ps2_data = ~(data_pl | dev_data_low);

  always #10 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .clrn(clrn), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_clk_pull_low(clk_pl),
    .ps2_data_pull_low(data_pl), .busy(busy), .done(done), .ack_err(ack_err),
    .timeout_err(timeout_err)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // expected outcome bits are {done, ack_err, timeout_err}
  typedef struct { logic [7:0] data; logic [2:0] kind; } exp_t;
  exp_t       exp_q[$];
  logic [9:0] rx_q[$];   // {stop, parity, byte} as read by the device

  int bfm_nclk  = 11;
  bit bfm_ack   = 1'b1;
  int bfm_falls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: odd parity over data+parity means parity=1 when the byte has an even number of ones
  function automatic logic exp_par(input logic [7:0] b);
    return ($countones(b) % 2) == 0;
  endfunction

  // ---------------- device model ----------------
  task automatic run_frame();
    logic [9:0] bits = '0;
    bfm_falls = 0;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= bfm_nclk; i++) begin
      if (i == 11 && bfm_ack) dev_data_low = 1'b1;
      dev_clk_low = 1'b1;
      bfm_falls   = i;
      repeat (HALF) @(negedge clk);
      if (i <= 10) bits[i-1] = ps2_data;   // device reads on the rising edge
      if (i == 10) rx_q.push_back(bits);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  initial begin : bfm
    forever begin
      @(negedge clk);
      while (ps2_clk !== 1'b0) @(negedge clk);
      while (ps2_clk !== 1'b1) @(negedge clk);
      if (ps2_data === 1'b0) run_frame();
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : mon
    int         run = 0, rts_cyc = 0;
    logic       prev_cp = 1'b0, prev_dp = 1'b0;
    exp_t       e;
    logic [9:0] r;
    forever begin
      @(negedge clk);
      if (!clrn) begin run = 0; prev_cp = 1'b0; prev_dp = 1'b0; continue; end
      if (clk_pl) run++;
      else if (prev_cp) begin
        check("inhibit_len", run, INH);
        check("start_bit_before_release", prev_dp, 1);
        rts_cyc = cyc;
        run = 0;
      end
      prev_cp = clk_pl;
      prev_dp = data_pl;
      if (done || ack_err || timeout_err) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: done=%b ack_err=%b timeout_err=%b with nothing outstanding",
                   done, ack_err, timeout_err);
        end else begin
          e = exp_q.pop_front();
          check("outcome", {done, ack_err, timeout_err}, e.kind);
          check("ready_at_end", {tx_ready, busy}, 2'b10);
          if (e.kind == 3'b001) begin
            check("timeout_delay", cyc - rts_cyc, TO);
            check("lines_released", {clk_pl, data_pl}, 2'b00);
          end else if (rx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame_missing: device saw no frame, expected byte %0h", e.data);
          end else begin
            r = rx_q.pop_front();
            check("byte", r[7:0], e.data);
            check("parity", r[8], exp_par(e.data));
            check("stop", r[9], 1);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [7:0] b, input logic [2:0] kind);
    int n = 0;
    repeat (50) @(negedge clk);
    while (tx_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin checks++; errors++; $display("FAIL ready_wait: tx_ready stuck at %b, expected 1", tx_ready); end
    bfm_falls = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    if (kind != 3'b000) exp_q.push_back('{data: b, kind: kind});
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin @(negedge clk); n++; end
    if (n >= bound) begin checks++; errors++; $display("FAIL idle_wait: busy=%b after %0d cycles, expected 0", busy, n); end
  endtask

  task automatic wait_falls(input int k);
    int n = 0;
    while (bfm_falls < k && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin checks++; errors++; $display("FAIL fall_wait: device fall count %0d, expected %0d", bfm_falls, k); end
  endtask

  task automatic poke_busy();
    check("ready_low_while_busy", tx_ready, 0);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin : main
    logic [7:0] b;
    bit ack;
    clrn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_pulls", {clk_pl, data_pl}, 2'b00);
    check("reset_pulses", {done, ack_err, timeout_err}, 3'b000);
    @(negedge clk) clrn = 1'b1;

    // set-LEDs, then the parity corner bytes
    send(8'hED, 3'b100); wait_idle(3000);
    send(8'h01, 3'b100); wait_idle(3000);
    send(8'hFF, 3'b100); wait_idle(3000);

    // device withholds the ACK
    bfm_ack = 1'b0;
    b = 8'($urandom);
    send(b, 3'b010); wait_idle(3000);
    bfm_ack = 1'b1;

    // requests while busy are dropped
    b = 8'($urandom);
    send(b, 3'b100);
    repeat (10) @(negedge clk);
    poke_busy();
    wait_falls(3);
    poke_busy();
    wait_idle(3000);
    repeat (200) @(negedge clk);
    check("no_second_frame", busy, 0);

    // random bytes with random ACK behaviour
    repeat (6) begin
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      bfm_ack = ack;
      send(b, ack ? 3'b100 : 3'b010);
      wait_idle(3000);
    end
    bfm_ack = 1'b1;

    // reset in the middle of a frame
    bfm_nclk = 4;
    send(8'($urandom), 3'b000);
    wait_falls(4);
    repeat (6) @(negedge clk);
    clrn = 1'b0;
    @(posedge clk); #1;
    check("abort_pulls", {clk_pl, data_pl}, 2'b00);
    check("abort_ready", {tx_ready, busy}, 2'b10);
    @(negedge clk) clrn = 1'b1;
    repeat (3 * HALF) @(negedge clk);

    // device never clocks
    bfm_nclk = 0;
`ifdef PS2_HOST_TX_TIMEOUT_EN
    send(8'($urandom), 3'b001);
    wait_idle(TO + INH + 200);
`else
    send(8'($urandom), 3'b000);
    repeat (INH + 3000) @(negedge clk);
    check("stuck_busy", busy, 1);
    clrn = 1'b0;
    @(negedge clk) clrn = 1'b1;
`endif
    bfm_nclk = 11;

    // recovery
    send(8'hFF, 3'b100); wait_idle(3000);
    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
